// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO.
// Latency: 34 cycles per mult/div (issue + 32 RUN + FIN); MD_FAST_MUL_EN makes mult/multu 2 cycles.
// Backpressure: busy (combinational) stalls the pipeline in the issue and RUN cycles; cancel drops it.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid,
  input  logic [7:0]      MDop,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            cancel,
  output logic            busy,
  output logic [XLEN-1:0] md_result,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam int DW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            div_q, div_d;       // latched op is a divide
  logic            neg_q, neg_d;       // product / quotient must be negated
  logic            rem_neg_q, rem_neg_d; // remainder takes dividend sign
  logic            dz_q, dz_d;         // divide by zero
  logic [XLEN-1:0] src_q, src_d;       // raw rs, reported as HI on divide by zero
  logic [XLEN-1:0] a_q, a_d;           // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_q, acc_d;       // product high half or partial remainder
  logic [XLEN-1:0] sh_q, sh_d;         // multiplier/product low half or dividend/quotient

  // Decode of the one-hot MDop vector
  logic op_div, op_divu, op_mult, op_multu, op_mfhi, op_mflo, op_mthi, op_mtlo;
  assign {op_div, op_divu, op_mult, op_multu, op_mfhi, op_mflo, op_mthi, op_mtlo} = MDop;

  logic issue_ok, start, is_signed, is_div_op, rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  assign issue_ok  = md_valid & ~cancel & (state_q == IDLE);
  assign start     = issue_ok & (op_div | op_divu | op_mult | op_multu);
  assign is_signed = op_div | op_mult;
  assign is_div_op = op_div | op_divu;
  assign rs_neg    = is_signed & rs_data[XLEN-1];
  assign rt_neg    = is_signed & rt_data[XLEN-1];
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;

  // Shift-add multiply step: conditionally add, then shift {acc,sh} right by one
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_acc_nx, mul_sh_nx;
  assign mul_sum    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc_nx = mul_sum[XLEN:1];
  assign mul_sh_nx  = {mul_sum[0], sh_q[XLEN-1:1]};

  // Restoring divide step: shift next dividend bit into remainder, trial subtract
  logic [XLEN:0]   div_trial, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_acc_nx, div_sh_nx;
  assign div_trial  = {acc_q, sh_q[XLEN-1]};
  assign div_diff   = div_trial - {1'b0, a_q};
  assign div_ge     = ~div_diff[XLEN];
  assign div_acc_nx = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
  assign div_sh_nx  = {sh_q[XLEN-2:0], div_ge};

  // Sign fix-up applied in FIN
  logic [DW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fin_hi, fin_lo;
  assign prod     = {acc_q, sh_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -sh_q : sh_q;
  assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

  // Final HI/LO values selected by op type and divide-by-zero
  always_comb begin
    fin_hi = prod_fix[DW-1:XLEN];
    fin_lo = prod_fix[XLEN-1:0];
    if (div_q) begin
      if (dz_q) begin
        fin_hi = src_q;
        fin_lo = '1;
      end else begin
        fin_hi = rem_fix;
        fin_lo = quo_fix;
      end
    end
  end

  // Next-state logic for the FSM, iteration datapath and HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    src_d     = src_q;
    a_d       = a_q;
    acc_d     = acc_q;
    sh_d      = sh_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_d     = is_div_op;
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          dz_d      = is_div_op & (rt_data == '0);
          src_d     = rs_data;
          acc_d     = '0;
          if (is_div_op) begin
            a_d  = rt_mag;
            sh_d = rs_mag;
          end else begin
            a_d  = rs_mag;
            sh_d = rt_mag;
`ifdef MD_FAST_MUL_EN
            {acc_d, sh_d} = DW'(rs_mag) * DW'(rt_mag);
            state_d       = FIN;
`endif
          end
        end else if (issue_ok) begin
          if (op_mthi) hi_d = rs_data;
          if (op_mtlo) lo_d = rs_data;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_d = div_acc_nx;
          sh_d  = div_sh_nx;
        end else begin
          acc_d = mul_acc_nx;
          sh_d  = mul_sh_nx;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = FIN;
      end
      FIN: begin
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flush abandons any operation in flight and leaves HI/LO alone
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers; reset clears FSM, counter and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      src_q     <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      src_q     <= src_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
    end
  end

  // busy is low in FIN so the pipeline moves on at the edge HI/LO are written
  assign busy = start | ((state_q == RUN) & ~cancel);

  // Reads return the registered HI/LO
  always_comb begin
    md_result = '0;
    if (md_valid) begin
      if (op_mfhi)      md_result = hi_q;
      else if (op_mflo) md_result = lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed ops, expected HI/LO/busy queued at issue,
// a negedge monitor pops and compares on completion (busy falling) and on reads.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, md_valid, cancel;
  logic [7:0]  MDop;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] md_result, hi, lo;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .MDop(MDop),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .busy(busy), .md_result(md_result), .hi(hi), .lo(lo)
  );

  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_DIVU  = 8'h40;
  localparam logic [7:0] OP_MULT  = 8'h20;
  localparam logic [7:0] OP_MULTU = 8'h10;
  localparam logic [7:0] OP_MFHI  = 8'h08;
  localparam logic [7:0] OP_MFLO  = 8'h04;
  localparam logic [7:0] OP_MTHI  = 8'h02;
  localparam logic [7:0] OP_MTLO  = 8'h01;

  localparam int DIV_BUSY = 33;
`ifdef MD_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_cyc;
  } exp_t;

  exp_t        cq[$];
  logic [31:0] rq[$];
  int checks   = 0;
  int failures = 0;
  int busy_run = 0;
  bit pend     = 1'b0;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completion is the cycle busy drops without cancel/reset;
  // HI/LO are compared one cycle later, after the FIN edge.
  always @(negedge clk) begin
    if (pend) begin
      chk({cur.name, " hi"}, hi, cur.hi);
      chk({cur.name, " lo"}, lo, cur.lo);
      pend = 1'b0;
    end
    if (rst || cancel) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (cq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected completion after %0d busy cycles", busy_run);
      end else begin
        cur = cq.pop_front();
        chk({cur.name, " busy cycles"}, 32'(busy_run), 32'(cur.busy_cyc));
        pend = 1'b1;
      end
      busy_run = 0;
    end
    if (!rst && md_valid && (MDop == OP_MFHI || MDop == OP_MFLO)) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected read md_result=%h", md_result);
      end else begin
        chk("md_result read", md_result, rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt);
    MDop     = op;
    rs_data  = rs;
    rt_data  = rt;
    md_valid = 1'b1;
    tick();
    md_valid = 1'b0;
    MDop     = 8'h00;
  endtask

  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy);
    exp_t e;
    e.name     = name;
    e.hi       = ehi;
    e.lo       = elo;
    e.busy_cyc = ebusy;
    cq.push_back(e);
    issue(op, rs, rt);
    for (int i = 0; i < 80 && (cq.size() != 0 || pend); i++) tick();
    if (cq.size() != 0 || pend) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no completion within 80 cycles", name);
    end
  endtask

  initial begin
    rst = 1'b1; md_valid = 1'b0; cancel = 1'b0; MDop = 8'h00; rs_data = '0; rt_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset md_result", md_result, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    tick();

    run_op("divu 100/7",     OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_BUSY);
    run_op("div -7/2",       OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  DIV_BUSY);
    run_op("div min/-1",     OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  DIV_BUSY);
    run_op("mult -1*2",      OP_MULT,  32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFE,  MUL_BUSY);
    run_op("multu ffff*2",   OP_MULTU, 32'hFFFFFFFF,  32'd2,         32'h1,         32'hFFFFFFFE,  MUL_BUSY);
    run_op("mult min*min",   OP_MULT,  32'h80000000,  32'h80000000,  32'h40000000,  32'h0,         MUL_BUSY);
    run_op("divu by zero",   OP_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFFFFFF,  DIV_BUSY);
    run_op("div by zero",    OP_DIV,   32'hFFFFFFF9,  32'h0,         32'hFFFFFFF9,  32'hFFFFFFFF,  DIV_BUSY);

    // Write then read back on the following cycle
    issue(OP_MTHI, 32'hA5A5, 32'h0);
    rq.push_back(32'hA5A5);
    issue(OP_MFHI, 32'h0, 32'h0);
    rq.push_back(32'hFFFFFFFF);
    issue(OP_MFLO, 32'h0, 32'h0);
    MDop = OP_MFHI;
    @(negedge clk);
    chk("mfhi without md_valid", md_result, 32'h0);
    tick();
    MDop = 8'h00;

    // Cancel during RUN cycle 10 leaves HI/LO untouched
    issue(OP_MTHI, 32'h5A5A, 32'h0);
    issue(OP_MTLO, 32'h1111, 32'h0);
    issue(OP_DIV, 32'h100, 32'd3);
    repeat (9) tick();
    cancel = 1'b1;
    @(negedge clk);
    chk("busy during cancel", 32'(busy), 32'd0);
    tick();
    cancel = 1'b0;
    @(negedge clk);
    chk("busy after cancel", 32'(busy), 32'd0);
    tick();
    repeat (40) tick();
    chk("hi after cancel", hi, 32'h5A5A);
    chk("lo after cancel", lo, 32'h1111);

    // mtlo and a start both suppressed by cancel
    cancel = 1'b1;
    issue(OP_MTLO, 32'h2222, 32'h0);
    cancel = 1'b0;
    chk("lo mtlo cancelled", lo, 32'h1111);
    cancel = 1'b1;
    MDop = OP_DIVU; rs_data = 32'd50; rt_data = 32'd5; md_valid = 1'b1;
    tick();
    md_valid = 1'b0; MDop = 8'h00; cancel = 1'b0;
    @(negedge clk);
    chk("busy start cancelled", 32'(busy), 32'd0);
    tick();

    // Reset in the middle of a divide, then a divu right after reset
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("busy after mid reset", 32'(busy), 32'd0);
    chk("hi after mid reset", hi, 32'h0);
    chk("lo after mid reset", lo, 32'h0);
    tick();
    rst = 1'b0;
    run_op("divu after reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
